// File: rtl/matmul_pkg.sv
// Shared types and constants for the matmul_core sequencer and its MAC lanes.
package matmul_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 8;
    localparam int PROD_W = 32;

    localparam logic [ADDR_W-1:0] A_BASE_DEF = 8'd0;
    localparam logic [ADDR_W-1:0] B_BASE_DEF = 8'd64;
    localparam logic [ADDR_W-1:0] C_BASE_DEF = 8'd128;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_LAST,
        ST_WRITE,
        ST_DONE
    } state_t;

endpackage

// File: rtl/mac_lane.sv
// One signed 16x16 multiply-accumulate lane with 16-bit result reduction.
// MATMUL_SAT_EN selects clamping to the 16-bit signed range instead of wrap-around.
module mac_lane
    import matmul_pkg::*;
#(
    parameter int ACC_W = 40
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              i_clear,
    input  logic              i_acc_en,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_result
);

    logic [PROD_W-1:0] w_a_ext;
    logic [PROD_W-1:0] w_b_ext;
    logic [PROD_W-1:0] w_prod;
    logic [ACC_W-1:0]  r_acc;

    // Low 32 bits of the extended product equal the exact signed 16x16 product.
    assign w_a_ext = {{(PROD_W-DATA_W){i_a[DATA_W-1]}}, i_a};
    assign w_b_ext = {{(PROD_W-DATA_W){i_b[DATA_W-1]}}, i_b};
    assign w_prod  = w_a_ext * w_b_ext;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_acc <= '0;
        end else if (i_clear) begin
            r_acc <= '0;
        end else if (i_acc_en) begin
            r_acc <= r_acc + {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};
        end
    end

`ifdef MATMUL_SAT_EN
    logic w_ovf;
    // In range only when every bit above bit 14 matches the sign.
    assign w_ovf    = !((&r_acc[ACC_W-1:DATA_W-1]) || !(|r_acc[ACC_W-1:DATA_W-1]));
    assign o_result = w_ovf ? (r_acc[ACC_W-1] ? 16'h8000 : 16'h7FFF) : r_acc[DATA_W-1:0];
`else
    logic w_acc_hi_unused;
    assign w_acc_hi_unused = ^r_acc[ACC_W-1:DATA_W];
    assign o_result        = r_acc[DATA_W-1:0];
`endif

endmodule

// File: rtl/matmul_core.sv
// Sequencer for C = A x B over a 4-port data memory using two MAC lanes.
// MATMUL_SAT_EN (optional) makes the lanes saturate results instead of wrapping.
module matmul_core
    import matmul_pkg::*;
#(
    parameter int                N      = 4,
    parameter logic [ADDR_W-1:0] A_BASE = A_BASE_DEF,
    parameter logic [ADDR_W-1:0] B_BASE = B_BASE_DEF,
    parameter logic [ADDR_W-1:0] C_BASE = C_BASE_DEF,
    parameter int                ACC_W  = 40
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr0,
    output logic [ADDR_W-1:0] mem_addr1,
    output logic [ADDR_W-1:0] mem_addr2,
    output logic [ADDR_W-1:0] mem_addr3,
    output logic [DATA_W-1:0] mem_datain0,
    output logic [DATA_W-1:0] mem_datain1,
    output logic [DATA_W-1:0] mem_datain2,
    output logic [DATA_W-1:0] mem_datain3,
    output logic              mem_write_en0,
    output logic              mem_write_en1,
    output logic              mem_write_en2,
    output logic              mem_write_en3,
    input  logic [DATA_W-1:0] mem_dataout0,
    input  logic [DATA_W-1:0] mem_dataout1,
    input  logic [DATA_W-1:0] mem_dataout2,
    input  logic [DATA_W-1:0] mem_dataout3,
    output state_t            o_dbg_state
);

    localparam int CNT_W = 4;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_i, r_j, r_k;
    logic [CNT_W-1:0] w_i_nxt, w_j_nxt, w_k_nxt;
    logic             r_issue_d;
    logic             w_clear;
    logic [DATA_W-1:0] w_res0, w_res1;
    logic [ADDR_W-1:0] w_row_a, w_row_b, w_row_c;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state   <= ST_IDLE;
            r_i       <= '0;
            r_j       <= '0;
            r_k       <= '0;
            r_issue_d <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_i       <= w_i_nxt;
            r_j       <= w_j_nxt;
            r_k       <= w_k_nxt;
            r_issue_d <= (r_state == ST_ISSUE);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_i_nxt     = r_i;
        w_j_nxt     = r_j;
        w_k_nxt     = r_k;
        w_clear     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_ISSUE;
                    w_i_nxt     = '0;
                    w_j_nxt     = '0;
                    w_k_nxt     = '0;
                    w_clear     = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (r_k == CNT_W'(N-1)) begin
                    w_k_nxt     = '0;
                    w_state_nxt = ST_LAST;
                end else begin
                    w_k_nxt = r_k + 1'b1;
                end
            end
            ST_LAST: w_state_nxt = ST_WRITE;
            ST_WRITE: begin
                // Results are consumed this cycle, so the next pair starts from zero.
                w_clear = 1'b1;
                if (r_j == CNT_W'(N-2)) begin
                    w_j_nxt = '0;
                    if (r_i == CNT_W'(N-1)) begin
                        w_i_nxt     = '0;
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_i_nxt     = r_i + 1'b1;
                        w_state_nxt = ST_ISSUE;
                    end
                end else begin
                    w_j_nxt     = r_j + CNT_W'(2);
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_row_a = A_BASE + ADDR_W'(r_i) * ADDR_W'(N);
    assign w_row_b = B_BASE + ADDR_W'(r_k) * ADDR_W'(N);
    assign w_row_c = C_BASE + ADDR_W'(r_i) * ADDR_W'(N) + ADDR_W'(r_j);

    always_comb begin
        mem_addr0     = '0;
        mem_addr1     = '0;
        mem_addr2     = '0;
        mem_addr3     = '0;
        mem_datain0   = '0;
        mem_datain2   = '0;
        mem_write_en0 = 1'b0;
        mem_write_en2 = 1'b0;
        case (r_state)
            ST_ISSUE: begin
                mem_addr0 = w_row_a + ADDR_W'(r_k);
                mem_addr1 = w_row_b + ADDR_W'(r_j);
                mem_addr2 = w_row_a + ADDR_W'(r_k);
                mem_addr3 = w_row_b + ADDR_W'(r_j) + 8'd1;
            end
            ST_WRITE: begin
                mem_addr0     = w_row_c;
                mem_addr2     = w_row_c + 8'd1;
                mem_datain0   = w_res0;
                mem_datain2   = w_res1;
                mem_write_en0 = 1'b1;
                mem_write_en2 = 1'b1;
            end
            default: ;
        endcase
    end

    assign mem_datain1   = '0;
    assign mem_datain3   = '0;
    assign mem_write_en1 = 1'b0;
    assign mem_write_en3 = 1'b0;

    assign busy        = (r_state == ST_ISSUE) || (r_state == ST_LAST) || (r_state == ST_WRITE);
    assign done        = (r_state == ST_DONE);
    assign o_dbg_state = r_state;

    // Operand data for an ISSUE cycle lands one cycle later; accumulate then.
    mac_lane #(.ACC_W(ACC_W)) u_lane0 (
        .clock    (clock),
        .resetn   (resetn),
        .i_clear  (w_clear),
        .i_acc_en (r_issue_d),
        .i_a      (mem_dataout0),
        .i_b      (mem_dataout1),
        .o_result (w_res0)
    );

    mac_lane #(.ACC_W(ACC_W)) u_lane1 (
        .clock    (clock),
        .resetn   (resetn),
        .i_clear  (w_clear),
        .i_acc_en (r_issue_d),
        .i_a      (mem_dataout2),
        .i_b      (mem_dataout3),
        .o_result (w_res1)
    );

endmodule

// File: tb/tb_matmul_core.sv
// Self-checking bench for matmul_core with a behavioural 4-port memory and write scoreboard.
module tb_matmul_core;
    import matmul_pkg::*;

    localparam int N      = 4;
    localparam int NN     = N * N;
    localparam int RUN_CY = (NN / 2) * (N + 2) + 1;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        busy, done;
    logic [7:0]  mem_addr0, mem_addr1, mem_addr2, mem_addr3;
    logic [15:0] mem_datain0, mem_datain1, mem_datain2, mem_datain3;
    logic        mem_write_en0, mem_write_en1, mem_write_en2, mem_write_en3;
    logic [15:0] mem_dataout0, mem_dataout1, mem_dataout2, mem_dataout3;
    state_t      o_dbg_state;

    logic [15:0] mem [256];

    int n_cmp = 0;
    int n_err = 0;
    int n_writes = 0;
    logic [23:0] exp_q[$];

    typedef struct {
        int          a_mode;
        logic [15:0] a_val;
        int          b_mode;
        logic [15:0] b_val;
        int          kind;   // 0: model only, 1: uniform exp_c, 2: C[idx] == idx
        logic [15:0] exp_c;
    } vec_t;

    vec_t vecs[5];

    always #5 clock = ~clock;

    matmul_core dut (
        .clock         (clock),
        .resetn        (resetn),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .mem_addr0     (mem_addr0),
        .mem_addr1     (mem_addr1),
        .mem_addr2     (mem_addr2),
        .mem_addr3     (mem_addr3),
        .mem_datain0   (mem_datain0),
        .mem_datain1   (mem_datain1),
        .mem_datain2   (mem_datain2),
        .mem_datain3   (mem_datain3),
        .mem_write_en0 (mem_write_en0),
        .mem_write_en1 (mem_write_en1),
        .mem_write_en2 (mem_write_en2),
        .mem_write_en3 (mem_write_en3),
        .mem_dataout0  (mem_dataout0),
        .mem_dataout1  (mem_dataout1),
        .mem_dataout2  (mem_dataout2),
        .mem_dataout3  (mem_dataout3),
        .o_dbg_state   (o_dbg_state)
    );

    // Registered-read memory model
    always @(posedge clock) begin
        mem_dataout0 <= mem[mem_addr0];
        mem_dataout1 <= mem[mem_addr1];
        mem_dataout2 <= mem[mem_addr2];
        mem_dataout3 <= mem[mem_addr3];
        if (mem_write_en0) mem[mem_addr0] <= mem_datain0;
        if (mem_write_en1) mem[mem_addr1] <= mem_datain1;
        if (mem_write_en2) mem[mem_addr2] <= mem_datain2;
        if (mem_write_en3) mem[mem_addr3] <= mem_datain3;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Write monitor and scoreboard
    always @(negedge clock) begin
        if (resetn) begin
            check("we1_we3_low", {30'd0, mem_write_en1, mem_write_en3}, 32'd0);
            if (mem_write_en0 || mem_write_en2) begin
                n_writes++;
                check("we0_eq_we2", {31'd0, mem_write_en0}, {31'd0, mem_write_en2});
                check("wr_addr_range",
                      {31'd0, (mem_addr0 >= 8'd128 && mem_addr0 <= 8'd143 &&
                               mem_addr2 >= 8'd128 && mem_addr2 <= 8'd143)}, 32'd1);
                if (exp_q.size() >= 2) begin
                    check("sb_lane0", {8'd0, mem_addr0, mem_datain0}, {8'd0, exp_q.pop_front()});
                    check("sb_lane1", {8'd0, mem_addr2, mem_datain2}, {8'd0, exp_q.pop_front()});
                end else begin
                    check("sb_underflow", exp_q.size(), 32'd2);
                end
            end
        end
    end

    function automatic logic [15:0] elem(input int mode, input logic [15:0] val, input int r, input int c);
        case (mode)
            0: return val;
            1: return (r == c) ? 16'd1 : 16'd0;
            2: return 16'(r * N + c);
            3: return 16'($urandom_range(0, 16)) - 16'd8;
            default: return 16'($urandom_range(0, 65535));
        endcase
    endfunction

    function automatic logic [15:0] reduce16(input longint v);
`ifdef MATMUL_SAT_EN
        if (v > 32767) return 16'h7FFF;
        if (v < -32768) return 16'h8000;
`endif
        return 16'(v);
    endfunction

    task automatic load_vec(input vec_t v);
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                mem[r * N + c]      = elem(v.a_mode, v.a_val, r, c);
                mem[64 + r * N + c] = elem(v.b_mode, v.b_val, r, c);
            end
        end
        for (int idx = 0; idx < NN; idx++) mem[128 + idx] = 16'hDEAD;
    endtask

    task automatic push_expected();
        longint acc;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j += 2) begin
                for (int l = 0; l < 2; l++) begin
                    acc = 0;
                    for (int k = 0; k < N; k++)
                        acc += longint'($signed(mem[i * N + k])) * longint'($signed(mem[64 + k * N + j + l]));
                    exp_q.push_back({8'(128 + i * N + j + l), reduce16(acc)});
                end
            end
        end
    endtask

    task automatic check_c(input vec_t v);
        for (int idx = 0; idx < NN; idx++) begin
            if (v.kind == 1) check("c_uniform", {16'd0, mem[128 + idx]}, {16'd0, v.exp_c});
            if (v.kind == 2) check("c_ramp", {16'd0, mem[128 + idx]}, idx);
        end
    endtask

    task automatic run_mult(input bit restart_mid, input int abort_at, output int cyc);
        bit busy_bad;
        busy_bad = 1'b0;
        cyc      = 0;
        n_writes = 0;
        @(negedge clock);
        start = 1'b1;
        while (1) begin
            @(negedge clock);
            cyc++;
            if (cyc == 1) start = 1'b0;
            if (restart_mid && cyc == 10) start = 1'b1;
            if (restart_mid && cyc == 12) start = 1'b0;
            if (abort_at != 0 && cyc == abort_at) return;
            if (done) break;
            if (!busy) busy_bad = 1'b1;
            if (cyc >= 300) begin
                check("run_timeout", cyc, RUN_CY);
                return;
            end
        end
        check("busy_in_done", {31'd0, busy}, 32'd0);
        check("busy_during_run", {31'd0, busy_bad}, 32'd0);
        check("done_latency", cyc, RUN_CY);
        check("write_count", n_writes, NN / 2);
        check("sb_drained", exp_q.size(), 32'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy_done"}, {30'd0, busy, done}, 32'd0);
        check({tag, "_addr"}, {mem_addr0, mem_addr1, mem_addr2, mem_addr3}, 32'd0);
        check({tag, "_datain02"}, {mem_datain0, mem_datain2}, 32'd0);
        check({tag, "_datain13"}, {mem_datain1, mem_datain3}, 32'd0);
        check({tag, "_we"}, {28'd0, mem_write_en0, mem_write_en1, mem_write_en2, mem_write_en3}, 32'd0);
        check({tag, "_state"}, {29'd0, o_dbg_state}, {29'd0, ST_IDLE});
    endtask

    initial begin
        int cyc;
        vecs[0] = '{1, 16'h0000, 2, 16'h0000, 2, 16'h0000};
        vecs[1] = '{0, 16'h0002, 0, 16'hFFFD, 1, 16'hFFE8};
`ifdef MATMUL_SAT_EN
        vecs[2] = '{0, 16'h7FFF, 0, 16'h7FFF, 1, 16'h7FFF};
`else
        vecs[2] = '{0, 16'h7FFF, 0, 16'h7FFF, 1, 16'h0004};
`endif
        vecs[3] = '{3, 16'h0000, 3, 16'h0000, 0, 16'h0000};
        vecs[4] = '{4, 16'h0000, 4, 16'h0000, 0, 16'h0000};

        for (int a = 0; a < 256; a++) mem[a] = 16'h0000;
        #1;
        check_outputs_zero("reset");
        repeat (3) @(negedge clock);
        resetn = 1'b1;

        for (int v = 0; v < 5; v++) begin
            load_vec(vecs[v]);
            push_expected();
            run_mult(1'b0, 0, cyc);
            check_c(vecs[v]);
        end

        // Second start while busy must not disturb the run
        load_vec(vecs[0]);
        push_expected();
        run_mult(1'b1, 0, cyc);
        check_c(vecs[0]);

        // Reset in cycle 20 aborts; a later start completes normally
        load_vec(vecs[1]);
        push_expected();
        run_mult(1'b0, 20, cyc);
        resetn = 1'b0;
        @(posedge clock);
        #1;
        check_outputs_zero("abort");
        exp_q.delete();
        @(negedge clock);
        resetn = 1'b1;
        load_vec(vecs[0]);
        push_expected();
        run_mult(1'b0, 0, cyc);
        check_c(vecs[0]);

        repeat (2) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/matmul_core.md
# matmul_core

Sequencer and arithmetic stage that sits directly upstream of the 4-port 256×16 data memory and drives all four of its ports. On a start pulse it computes C = A × B for square N×N signed 16-bit matrices stored row-major in that memory. It uses two parallel multiply-accumulate lanes, each owning two memory ports, and writes the results back into the same memory. A host/loader fills A and B, pulses start, and waits for done.

## Interface
Parameters:
- N, 4: matrix dimension; even, 2..8.
- A_BASE, 8'd0: base address of A.
- B_BASE, 8'd64: base address of B.
- C_BASE, 8'd128: base address of C.
- ACC_W, 40: accumulator width, signed.

Ports:
- clock  in  1  single clock; all state changes on posedge.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  begin a multiply; sampled only in IDLE.
- busy  out  1  high while computing.
- done  out  1  one-cycle pulse on completion.
- mem_addr0..mem_addr3  out  8 each  memory port addresses.
- mem_datain0..mem_datain3  out  16 each  memory write data.
- mem_write_en0..mem_write_en3  out  1 each  memory write enables; 0 means read.
- mem_dataout0..mem_dataout3  in  16 each  registered memory read data, valid the cycle after the address.

## Operation
- Lane 0 uses ports 0 and 1 and computes C[i][j]. Lane 1 uses ports 2 and 3 and computes C[i][j+1]. j steps by 2; i is the outer loop.
- Operand reads:
  - port0 = A_BASE + i·N + k; port1 = B_BASE + k·N + j.
  - port2 = A_BASE + i·N + k; port3 = B_BASE + k·N + j + 1.
- All address arithmetic is 8-bit and wraps modulo 256.
- Arithmetic: signed 16×16 → 32-bit product, sign-extended into an ACC_W accumulator. The accumulator clears at the start of each column pair.
- Result reduction to 16 bits depends on the Configuration macro.
- FSM states:
  - IDLE: start=1 → ISSUE, with i=j=k=0 and accumulators cleared.
  - ISSUE: present addresses for k, increment k. After k=N-1 → LAST.
  - LAST: last operand data arrives; final accumulate → WRITE.
  - WRITE: mem_write_en0 and mem_write_en2 high, mem_addr0 = C_BASE+i·N+j, mem_addr2 = that address +1, reduced results on mem_datain0 and mem_datain2. Next column pair → ISSUE; after the final pair → DONE.
  - DONE: done=1 for one cycle → IDLE.
- Accumulation happens on every clock edge whose cycle follows an ISSUE cycle, i.e. in ISSUE cycles 2..N and in LAST.
- mem_write_en1 and mem_write_en3 are always 0. mem_write_en0/2 are high only in WRITE.
- start while not in IDLE is ignored. start held high re-triggers from IDLE after DONE.

## Timing
- Reset values: busy=0, done=0, all mem_addr=0, all mem_datain=0, all mem_write_en=0, state IDLE, counters and accumulators 0.
- Reset asserted mid-operation aborts immediately; partially written C contents are left as-is.
- Read latency is one cycle: the address presented in cycle t produces data in cycle t+1.
- Per column pair: N ISSUE cycles + 1 LAST + 1 WRITE = N+2 cycles.
- Total: (N²/2)·(N+2) cycles from the first ISSUE cycle to the last WRITE cycle; N=4 gives 48. The DONE cycle follows.
- busy is high from the cycle after start is sampled through the last WRITE cycle. busy=0 in DONE.

## Configuration
- MATMUL_SAT_EN defined: the accumulator is clamped to [-32768, 32767] before writing (0x8000 / 0x7FFF).
- MATMUL_SAT_EN undefined: the low 16 bits of the accumulator are written (wrap-around).

## Structure
- Shared package matmul_pkg holds:
  - the FSM state enum (IDLE, ISSUE, LAST, WRITE, DONE);
  - DATA_W=16, ADDR_W=8, PROD_W=32;
  - the default base-address constants.
- One sub-module, mac_lane, is instantiated twice. It holds a synchronous clear, an accumulate enable, the 16×16 signed multiply, the ACC_W register, and the 16-bit reduction including the MATMUL_SAT_EN logic.

## Test plan
- N=4, A=identity, B[r][c]=r·4+c; pulse start → C region 128..143 holds 0..15; done exactly 49 cycles after the start-sampling edge.
- N=4, A all 2, B all -3 (0xFFFD) → every C word = -24 (0xFFE8).
- N=4, A and B all 0x7FFF → with MATMUL_SAT_EN, C = 0x7FFF everywhere; without it, C = 0x0004.
- start pulsed again while busy → ignored; cycle count and C unchanged from the single-start run.
- resetn low in cycle 20 of a run → all outputs 0 next cycle, busy=0; a subsequent start completes correctly.
- Write-enable checker: mem_write_en1/3 never high; mem_write_en0/2 high exactly N²/2 cycles, each with an address in C_BASE..C_BASE+N²-1.
